// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the core-word to MIG UI bridge.
// Used by mem_word_bridge and, when MEM_LINE_BUFFER_EN is defined, mem_line_buffer.
package mem_bridge_pkg;

    localparam int unsigned APP_DATA_WIDTH = 128;
    localparam int unsigned APP_MASK_WIDTH = APP_DATA_WIDTH / 8;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        WR,
        RESP
    } state_t;

    // A set mask bit means the byte is NOT written, so only the selected word's nibble is clear.
    function automatic logic [APP_MASK_WIDTH-1:0] word_mask(input logic [1:0] sel);
        logic [APP_MASK_WIDTH-1:0] keep;
        keep      = '0;
        keep[3:0] = 4'hF;
        return ~(keep << {sel, 2'b00});
    endfunction

endpackage

// File: rtl/mem_line_buffer.sv
// One-line read buffer: tag compare, whole-line fill on read miss,
// and byte-enable update of the buffered line on a write hit.
module mem_line_buffer
    import mem_bridge_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [27:0]               lookup_tag,
    input  logic [1:0]                lookup_sel,
    output logic                      hit,
    output logic [31:0]               hit_word,
    input  logic                      fill_en,
    input  logic [27:0]               fill_tag,
    input  logic [APP_DATA_WIDTH-1:0] fill_data,
    input  logic                      wr_en,
    input  logic [27:0]               wr_tag,
    input  logic [1:0]                wr_sel,
    input  logic [31:0]               wr_word
);

    logic                      valid_q, valid_d;
    logic [27:0]               tag_q, tag_d;
    logic [APP_DATA_WIDTH-1:0] data_q, data_d;
    logic [APP_MASK_WIDTH-1:0] wr_mask;

    assign hit      = valid_q && (tag_q == lookup_tag);
    assign hit_word = data_q[{lookup_sel, 5'b00000} +: 32];
    assign wr_mask  = word_mask(wr_sel);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_data;
        end else if (wr_en && valid_q && (tag_q == wr_tag)) begin
            for (int unsigned b = 0; b < APP_MASK_WIDTH; b++) begin
                if (!wr_mask[b]) begin
                    data_d[8*b +: 8] = wr_word[8*(b%4) +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/mem_word_bridge.sv
// Converts one arbitrated 32-bit core word request into a single 128-bit MIG UI transaction.
// Define MEM_LINE_BUFFER_EN to add a one-line read buffer (mem_line_buffer).
module mem_word_bridge #(
    parameter int unsigned ADDR_WIDTH     = 28,
    parameter int unsigned APP_DATA_WIDTH = 128,
    parameter int unsigned APP_MASK_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init_calib_complete,
    input  logic [31:0]               mem_addr,
    input  logic                      mem_rden,
    input  logic                      mem_wren,
    input  logic [31:0]               mem_write_val,
    output logic [31:0]               mem_read_val,
    output logic                      mem_response,
    output logic                      busy,
    output logic [ADDR_WIDTH-1:0]     app_addr,
    output logic [2:0]                app_cmd,
    output logic                      app_en,
    input  logic                      app_rdy,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    input  logic                      app_wdf_rdy,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
    input  logic                      app_rd_data_valid
);

    import mem_bridge_pkg::*;

    state_t                    state_q, state_d;
    logic                      app_en_q, app_en_d;
    logic                      wdf_wren_q, wdf_wren_d;
    logic                      resp_q, resp_d;
    logic                      busy_q, busy_d;
    logic [2:0]                cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [APP_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [APP_MASK_WIDTH-1:0] wmask_q, wmask_d;
    logic [1:0]                sel_q, sel_d;
    logic [31:0]               rdval_q, rdval_d;

    logic [ADDR_WIDTH-1:0]     line_addr;
    logic                      wr_req, rd_req;
    logic                      unused_addr_bits;

    assign line_addr        = {mem_addr[ADDR_WIDTH:4], 3'b000};
    assign wr_req           = (state_q == IDLE) && init_calib_complete && mem_wren;
    assign rd_req           = (state_q == IDLE) && init_calib_complete && mem_rden && !mem_wren;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+1], mem_addr[1:0]};

`ifdef MEM_LINE_BUFFER_EN
    logic        buf_hit;
    logic [31:0] buf_word;
    logic [27:0] tag_q, tag_d;
    logic        buf_fill;

    assign buf_fill = (state_q == RD_WAIT) && app_rd_data_valid;

    mem_line_buffer u_line_buffer (
        .clk        (clk),
        .reset      (reset),
        .lookup_tag (mem_addr[31:4]),
        .lookup_sel (mem_addr[3:2]),
        .hit        (buf_hit),
        .hit_word   (buf_word),
        .fill_en    (buf_fill),
        .fill_tag   (tag_q),
        .fill_data  (app_rd_data),
        .wr_en      (wr_req),
        .wr_tag     (mem_addr[31:4]),
        .wr_sel     (mem_addr[3:2]),
        .wr_word    (mem_write_val)
    );
`endif

    always_comb begin
        state_d    = state_q;
        app_en_d   = app_en_q;
        wdf_wren_d = wdf_wren_q;
        resp_d     = 1'b0;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        sel_d      = sel_q;
        rdval_d    = rdval_q;
`ifdef MEM_LINE_BUFFER_EN
        tag_d      = tag_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d    = WR;
                    app_en_d   = 1'b1;
                    wdf_wren_d = 1'b1;
                    cmd_d      = CMD_WRITE;
                    addr_d     = line_addr;
                    wdata_d    = {(APP_DATA_WIDTH/32){mem_write_val}};
                    wmask_d    = word_mask(mem_addr[3:2]);
                end else if (rd_req) begin
`ifdef MEM_LINE_BUFFER_EN
                    if (buf_hit) begin
                        state_d = RESP;
                        resp_d  = 1'b1;
                        rdval_d = buf_word;
                    end else begin
                        state_d  = RD_CMD;
                        app_en_d = 1'b1;
                        cmd_d    = CMD_READ;
                        addr_d   = line_addr;
                        sel_d    = mem_addr[3:2];
                        tag_d    = mem_addr[31:4];
                    end
`else
                    state_d  = RD_CMD;
                    app_en_d = 1'b1;
                    cmd_d    = CMD_READ;
                    addr_d   = line_addr;
                    sel_d    = mem_addr[3:2];
`endif
                end
            end
            RD_CMD: begin
                if (app_rdy) begin
                    app_en_d = 1'b0;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid) begin
                    rdval_d = app_rd_data[{sel_q, 5'b00000} +: 32];
                    state_d = RESP;
                    resp_d  = 1'b1;
                end
            end
            WR: begin
                // Each strobe stays up until its own handshake; leave once both have been taken.
                app_en_d   = app_en_q && !app_rdy;
                wdf_wren_d = wdf_wren_q && !app_wdf_rdy;
                if (!app_en_d && !wdf_wren_d) begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            app_en_q   <= 1'b0;
            wdf_wren_q <= 1'b0;
            resp_q     <= 1'b0;
            busy_q     <= 1'b0;
            cmd_q      <= CMD_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '1;
            sel_q      <= '0;
            rdval_q    <= '0;
`ifdef MEM_LINE_BUFFER_EN
            tag_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            app_en_q   <= app_en_d;
            wdf_wren_q <= wdf_wren_d;
            resp_q     <= resp_d;
            busy_q     <= busy_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            sel_q      <= sel_d;
            rdval_q    <= rdval_d;
`ifdef MEM_LINE_BUFFER_EN
            tag_q      <= tag_d;
`endif
        end
    end

    assign mem_read_val = rdval_q;
    assign mem_response = resp_q;
    assign busy         = busy_q;
    assign app_addr     = addr_q;
    assign app_cmd      = cmd_q;
    assign app_en       = app_en_q;
    assign app_wdf_data = wdata_q;
    assign app_wdf_mask = wmask_q;
    assign app_wdf_wren = wdf_wren_q;
    assign app_wdf_end  = 1'b1;

endmodule

// File: tb/tb_mem_word_bridge.sv
// Self-checking bench for mem_word_bridge: behavioural MIG model, word-level reference memory,
// vector table, hand sequences for stalls/calibration/reset, and randomized traffic.
module tb_mem_word_bridge;

`ifdef MEM_LINE_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         calib;
    logic [31:0]  mem_addr, mem_write_val, mem_read_val;
    logic         mem_rden, mem_wren, mem_response, busy;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;
    logic [127:0] app_wdf_data, app_rd_data;
    logic [15:0]  app_wdf_mask;

    always #5 clk = ~clk;

    mem_word_bridge #(.ADDR_WIDTH(28), .APP_DATA_WIDTH(128), .APP_MASK_WIDTH(16)) dut (
        .clk(clk), .reset(rst), .init_calib_complete(calib),
        .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_write_val(mem_write_val), .mem_read_val(mem_read_val),
        .mem_response(mem_response), .busy(busy),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference memory: one 32-bit word per word address (addr[28:2]); untouched words follow a pattern.
    logic [31:0]  ref_words [int];
    logic [127:0] line_mem  [int];
    bit           mdl_buf_valid = 1'b0;
    logic [27:0]  mdl_buf_tag;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int key = int'(a[28:2]);
        if (ref_words.exists(key)) return ref_words[key];
        return {3'b000, a[28:2]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] get_line(input int idx);
        logic [127:0] l;
        if (line_mem.exists(idx)) return line_mem[idx];
        for (int k = 0; k < 4; k++) l[32*k +: 32] = (idx * 4 + k) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [27:0] exp_app_addr(input logic [31:0] a);
        logic [31:0] v = ((a >> 4) & 32'h01FF_FFFF) << 3;
        return v[27:0];
    endfunction

    function automatic logic [15:0] exp_mask(input logic [31:0] a);
        logic [15:0] m;
        for (int b = 0; b < 16; b++) m[b] = ((b / 4) != int'(a[3:2]));
        return m;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        logic [127:0] l;
        int idx = int'(a[28:4]);
        ref_words[int'(a[28:2])] = v;
        l = get_line(idx);
        l[32*int'(a[3:2]) +: 32] = v;
        line_mem[idx] = l;
    endtask

    // MIG UI model: programmable handshake stalls, fixed read latency, masked line writes.
    int cmd_stall = 0, wdf_stall = 0, rd_lat = 3;
    int cyc = 0, cmd_cnt = 0, rd_cmd_cnt = 0, wr_cmd_cnt = 0, resp_cnt = 0, en_cycles = 0;
    int cmd_acc_cyc = 0, wdf_acc_cyc = 0;
    bit en_drop_seen = 1'b0;
    logic [27:0]  last_addr;
    logic [2:0]   last_cmd;
    logic [127:0] last_wdata;
    logic [15:0]  last_mask;
    int rd_idx_q[$];
    int rd_due_q[$];

    initial begin
        int cmd_wait = 0, wdf_wait = 0;
        bit w_addr_v = 1'b0, w_data_v = 1'b0;
        int w_idx = 0;
        logic [127:0] w_data, l;
        logic [15:0]  w_mask;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0; app_rd_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_response === 1'b1) resp_cnt++;
            if (app_en === 1'b1) en_cycles++;
            if (app_wdf_wren === 1'b1 && app_en === 1'b0) en_drop_seen = 1'b1;
            app_rd_data_valid = 1'b0;
            if (app_en === 1'b1) begin
                if (cmd_wait >= cmd_stall) begin
                    app_rdy = 1'b1; cmd_wait = 0; cmd_cnt++; cmd_acc_cyc = cyc;
                    last_addr = app_addr; last_cmd = app_cmd;
                    if (app_cmd == 3'b001) begin
                        rd_cmd_cnt++;
                        rd_idx_q.push_back(int'(app_addr >> 3));
                        rd_due_q.push_back(cyc + rd_lat);
                    end else begin
                        wr_cmd_cnt++; w_addr_v = 1'b1; w_idx = int'(app_addr >> 3);
                    end
                end else begin
                    app_rdy = 1'b0; cmd_wait++;
                end
            end else begin
                app_rdy = 1'b0; cmd_wait = 0;
            end
            if (app_wdf_wren === 1'b1) begin
                if (wdf_wait >= wdf_stall) begin
                    app_wdf_rdy = 1'b1; wdf_wait = 0; wdf_acc_cyc = cyc;
                    w_data = app_wdf_data; w_mask = app_wdf_mask; w_data_v = 1'b1;
                    last_wdata = app_wdf_data; last_mask = app_wdf_mask;
                end else begin
                    app_wdf_rdy = 1'b0; wdf_wait++;
                end
            end else begin
                app_wdf_rdy = 1'b0; wdf_wait = 0;
            end
            if (w_addr_v && w_data_v) begin
                l = get_line(w_idx);
                for (int b = 0; b < 16; b++) if (!w_mask[b]) l[8*b +: 8] = w_data[8*b +: 8];
                line_mem[w_idx] = l;
                w_addr_v = 1'b0; w_data_v = 1'b0;
            end
            if (rd_due_q.size() > 0 && cyc >= rd_due_q[0]) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = get_line(rd_idx_q[0]);
                void'(rd_idx_q.pop_front());
                void'(rd_due_q.pop_front());
            end
        end
    end

    task automatic wait_resp(output bit got, output int n);
        got = 1'b0; n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (mem_response === 1'b1) begin got = 1'b1; n = i; break; end
        end
    endtask

    task automatic drop_and_check_pulse(input string tag);
        mem_rden = 1'b0; mem_wren = 1'b0;
        @(negedge clk);
        chk({tag, " one-cycle resp"}, mem_response, 1'b0);
    endtask

    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input int cs, input int ws, input int lat,
                          input logic [27:0] e_addr, input logic [15:0] e_mask, input string tag);
        bit got; int n; int c0; int exp_cmds; logic [31:0] exp_rd;
        cmd_stall = cs; wdf_stall = ws; rd_lat = lat;
        c0 = cmd_cnt;
        exp_rd = ref_rd(a);
        exp_cmds = (!wr && BUF_EN && mdl_buf_valid && mdl_buf_tag == a[31:4]) ? 0 : 1;
        mem_addr = a; mem_write_val = wd; mem_wren = wr; mem_rden = !wr;
        wait_resp(got, n);
        chk({tag, " response"}, got, 1'b1);
        if (got) begin
            chk({tag, " cmd count"}, cmd_cnt - c0, exp_cmds);
            if (exp_cmds == 1) begin
                chk({tag, " app_addr"}, last_addr, e_addr);
                chk({tag, " app_cmd"}, last_cmd, wr ? 3'b000 : 3'b001);
            end
            if (wr) begin
                chk({tag, " wdf_mask"}, last_mask, e_mask);
                chk({tag, " wdf_data"}, last_wdata, {4{wd}});
                ref_words[int'(a[28:2])] = wd;
            end else begin
                chk({tag, " read_val"}, mem_read_val, exp_rd);
                if (exp_cmds == 1) begin mdl_buf_valid = 1'b1; mdl_buf_tag = a[31:4]; end
            end
        end
        drop_and_check_pulse(tag);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cs;
        int          ws;
        int          lat;
        logic [27:0] e_addr;
        logic [15:0] e_mask;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit got; int n; int c0, r0, e0, rc0, wc0;
        logic [31:0] a, wd;

        vecs.push_back('{0, 32'h0000_0014, 32'h0,          0, 0, 4, 28'h000_0008, 16'h0000});
        vecs.push_back('{1, 32'h0000_0028, 32'hCAFE_CAFE,  0, 0, 1, 28'h000_0010, 16'hF0FF});
        vecs.push_back('{1, 32'h0000_0104, 32'h1122_3344,  3, 0, 1, 28'h000_0080, 16'hFF0F});
        vecs.push_back('{1, 32'h0000_010C, 32'h0000_A5A5,  0, 5, 1, 28'h000_0080, 16'h0FFF});
        vecs.push_back('{1, 32'h0000_0100, 32'hDEAD_BEEF,  2, 2, 1, 28'h000_0080, 16'hFFF0});
        vecs.push_back('{0, 32'h0000_0028, 32'h0,          0, 0, 2, 28'h000_0010, 16'h0000});
        vecs.push_back('{0, 32'h0000_0107, 32'h0,          2, 0, 6, 28'h000_0080, 16'h0000});
        vecs.push_back('{0, 32'h0000_010F, 32'h0,          0, 0, 1, 28'h000_0080, 16'h0000});
        vecs.push_back('{0, 32'h0000_0100, 32'h0,          1, 0, 3, 28'h000_0080, 16'h0000});
        vecs.push_back('{0, 32'hE000_0014, 32'h0,          0, 0, 2, 28'h000_0008, 16'h0000});
        vecs.push_back('{0, 32'h1FFF_FFF8, 32'h0,          0, 0, 2, 28'hFFF_FFF8, 16'h0000});
        vecs.push_back('{1, 32'h1FFF_FFFC, 32'h89AB_CDEF,  1, 1, 1, 28'hFFF_FFF8, 16'h0FFF});
        vecs.push_back('{0, 32'h1FFF_FFF0, 32'h0,          0, 0, 1, 28'hFFF_FFF8, 16'h0000});

        preload(32'h0000_0010, 32'h1111_0000);
        preload(32'h0000_0014, 32'hBABE_BABE);
        preload(32'h0000_0018, 32'h2222_0000);
        preload(32'h0000_001C, 32'h3333_0000);

        rst = 1'b1; calib = 1'b1;
        mem_addr = '0; mem_write_val = '0; mem_rden = 1'b0; mem_wren = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset app_en", app_en, 1'b0);
        chk("reset app_wdf_wren", app_wdf_wren, 1'b0);
        chk("reset mem_response", mem_response, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset mem_read_val", mem_read_val, 32'h0);
        chk("reset app_cmd", app_cmd, 3'b001);
        chk("reset app_addr", app_addr, 28'h0);
        chk("app_wdf_end", app_wdf_end, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            en_drop_seen = 1'b0;
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].cs, vecs[i].ws, vecs[i].lat,
                   vecs[i].e_addr, vecs[i].e_mask, $sformatf("vec%0d", i));
            if (i == 3) begin
                chk("stall wdf accepted 5 after cmd", wdf_acc_cyc - cmd_acc_cyc, 5);
                chk("stall app_en dropped first", en_drop_seen, 1'b1);
            end
        end

        // Calibration low with both strobes: nothing issued, then the write wins.
        cmd_stall = 0; wdf_stall = 0;
        calib = 1'b0; mem_addr = 32'h0000_0030; mem_write_val = 32'h0F0F_1234;
        mem_rden = 1'b1; mem_wren = 1'b1;
        e0 = en_cycles;
        repeat (10) @(negedge clk);
        chk("calib low no app_en", en_cycles - e0, 0);
        chk("calib low not busy", busy, 1'b0);
        rc0 = rd_cmd_cnt; wc0 = wr_cmd_cnt;
        calib = 1'b1;
        wait_resp(got, n);
        chk("calib write response", got, 1'b1);
        drop_and_check_pulse("calib");
        chk("calib write issued", wr_cmd_cnt - wc0, 1);
        chk("calib no read issued", rd_cmd_cnt - rc0, 0);
        ref_words[int'(a[28:2] & 0) + 12] = 32'h0F0F_1234;

        // Reset while waiting for read data; the late data must be ignored.
        rd_lat = 15; c0 = cmd_cnt;
        mem_addr = 32'h0000_07F0; mem_rden = 1'b1;
        for (int i = 0; i < 20 && cmd_cnt == c0; i++) @(negedge clk);
        chk("rst-mid read cmd issued", cmd_cnt - c0, 1);
        repeat (2) @(negedge clk);
        chk("rst-mid busy before reset", busy, 1'b1);
        rst = 1'b1; mem_rden = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst-mid busy", busy, 1'b0);
        chk("rst-mid app_en", app_en, 1'b0);
        chk("rst-mid app_cmd", app_cmd, 3'b001);
        rst = 1'b0; mdl_buf_valid = 1'b0;
        r0 = resp_cnt;
        repeat (25) @(negedge clk);
        chk("rst-mid stale data consumed", rd_idx_q.size(), 0);
        chk("rst-mid no response", resp_cnt - r0, 0);
        chk("rst-mid read_val cleared", mem_read_val, 32'h0);
        chk("rst-mid idle", busy, 1'b0);

        for (int i = 0; i < 60; i++) begin
            a  = (BUF_EN ? 32'h0 : ($urandom & 32'hE000_0000)) | (32'($urandom_range(0, 63)) << 2);
            a  = a | 32'($urandom_range(0, 3));
            wd = $urandom;
            do_txn(bit'($urandom_range(0, 1)), a, wd, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(1, 6), exp_app_addr(a), exp_mask(a), $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef MEM_LINE_BUFFER_EN
        do_txn(0, 32'h0000_0040, 32'h0, 0, 0, 3, 28'h20, 16'h0, "buf rd40");
        c0 = cmd_cnt; mem_addr = 32'h0000_0044; mem_rden = 1'b1;
        wait_resp(got, n);
        chk("buf hit response", got, 1'b1);
        chk("buf hit latency", n <= 2, 1'b1);
        chk("buf hit no app_en", cmd_cnt - c0, 0);
        chk("buf hit data", mem_read_val, ref_rd(32'h0000_0044));
        drop_and_check_pulse("buf hit");
        do_txn(1, 32'h0000_0048, 32'h1357_9BDF, 0, 0, 1, 28'h20, 16'hF0FF, "buf wr48");
        c0 = cmd_cnt; mem_addr = 32'h0000_0048; mem_rden = 1'b1;
        wait_resp(got, n);
        chk("buf rd48 response", got, 1'b1);
        chk("buf rd48 no app_en", cmd_cnt - c0, 0);
        chk("buf rd48 new word", mem_read_val, 32'h1357_9BDF);
        drop_and_check_pulse("buf rd48");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
